// File: rtl/sseg_scan_monitor_if.sv
// Scanned display lines in, reassembled frame/status out.
// The slave modport is the monitor; the master modport is whatever drives the display lines.
interface sseg_scan_monitor_if #(
  parameter int NUM_DIGITS = 6
);
  logic [7:0]              sseg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] bcd_data_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic                    frame_valid_out;
  logic                    glyph_err_out;
  logic                    stale_out;

  modport master (
    output sseg_in, an_in,
    input  bcd_data_out, dp_out, frame_valid_out, glyph_err_out, stale_out
  );

  modport slave (
    input  sseg_in, an_in,
    output bcd_data_out, dp_out, frame_valid_out, glyph_err_out, stale_out
  );
endinterface

// File: rtl/sseg_scan_monitor.sv
// Decodes a multiplexed 7-segment scan back into a BCD frame with dp, glyph-error and stale flags.
// Frame output lands 2 + SETTLE_CYCLES + 1 cycles after the last digit's final input change.
module sseg_scan_monitor #(
  parameter int NUM_DIGITS     = 6,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                clk,
  input logic                rst,
  sseg_scan_monitor_if.slave mon
);
  localparam int                    TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]            SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [7:0]            SETTLE_HIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]         TO_MAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

  // Returns {invalid, nibble} for an active-high g..a pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h00:   decode = 5'h0F;
      default: decode = 5'h1E;
    endcase
  endfunction

  logic [7:0]              seg_m_q, s_seg_q, seg_p_q;
  logic [NUM_DIGITS-1:0]   an_m_q, s_an_q, an_p_q;
  logic [7:0]              settle_q, settle_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    err_q, err_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    fv_q, fv_d;
  logic                    gerr_q, gerr_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    stale_q, stale_d;

  logic                    change, onehot, sample;
  logic [NUM_DIGITS-1:0]   act;
  logic [4:0]              dec;

  // Two-flop synchronizers plus a previous-value copy for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m_q <= '1;
      s_seg_q <= '1;
      seg_p_q <= '1;
      an_m_q  <= '1;
      s_an_q  <= '1;
      an_p_q  <= '1;
    end else begin
      seg_m_q <= mon.sseg_in;
      s_seg_q <= seg_m_q;
      seg_p_q <= s_seg_q;
      an_m_q  <= mon.an_in;
      s_an_q  <= an_m_q;
      an_p_q  <= s_an_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q     <= '0;
      shadow_bcd_q <= '1;
      shadow_dp_q  <= '0;
      seen_q       <= '0;
      err_q        <= 1'b0;
      bcd_q        <= '1;
      dp_q         <= '0;
      fv_q         <= 1'b0;
      gerr_q       <= 1'b0;
      tcnt_q       <= '0;
      stale_q      <= 1'b0;
    end else begin
      settle_q     <= settle_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seen_q       <= seen_d;
      err_q        <= err_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      fv_q         <= fv_d;
      gerr_q       <= gerr_d;
      tcnt_q       <= tcnt_d;
      stale_q      <= stale_d;
    end
  end

  assign dec = decode(~s_seg_q[6:0]);

  always_comb begin
    change       = (s_seg_q != seg_p_q) || (s_an_q != an_p_q);
    act          = ~s_an_q;
    onehot       = (act != '0) && ((act & (act - DIG_ONE)) == '0);
    // Counter passes through SETTLE_HIT once per dwell, so a dwell samples at most once.
    sample       = !change && (settle_q == SETTLE_HIT) && onehot;

    settle_d     = settle_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    seen_d       = seen_q;
    err_d        = err_q;
    bcd_d        = bcd_q;
    dp_d         = dp_q;
    fv_d         = 1'b0;
    gerr_d       = gerr_q;

    if (change) begin
      settle_d = '0;
    end else if (settle_q != SETTLE_MAX) begin
      settle_d = settle_q + 8'd1;
    end

    if (sample) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (act[i]) begin
          shadow_bcd_d[4*i +: 4] = dec[3:0];
          shadow_dp_d[i]         = ~s_seg_q[7];
        end
      end
      seen_d = seen_q | act;
      err_d  = err_q | dec[4];
      if (seen_d == '1) begin
        bcd_d  = shadow_bcd_d;
        dp_d   = shadow_dp_d;
        gerr_d = err_d;
        fv_d   = 1'b1;
        seen_d = '0;
        err_d  = 1'b0;
      end
    end

    // Cleared alongside the frame pulse; stale lags the counter by one register.
    if (fv_d) begin
      tcnt_d = '0;
    end else if (tcnt_q != TO_MAX) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
    stale_d = (tcnt_q == TO_MAX);
  end

  assign mon.bcd_data_out    = bcd_q;
  assign mon.dp_out          = dp_q;
  assign mon.frame_valid_out = fv_q;
  assign mon.glyph_err_out   = gerr_q;
  assign mon.stale_out       = stale_q;
endmodule

// File: tb/tb_sseg_scan_monitor.sv
// Directed bench for sseg_scan_monitor: scans hand-built glyph frames and checks decoded frames and flags.
module tb_sseg_scan_monitor;
  localparam int SETTLE = 16;
  localparam int TOUT   = 1000;

  localparam logic [47:0] F123456  = {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [47:0] DP2      = {8'h82, 8'h92, 8'h99, 8'h30, 8'hA4, 8'hF9};
  localparam logic [47:0] D4_ALL   = {8'h82, 8'h00, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [47:0] D4_BLANK = {8'h82, 8'hFF, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [47:0] D4_BAD   = {8'h82, 8'hB6, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [47:0] NINES    = {6{8'h90}};
  localparam logic [47:0] SEVENS   = {6{8'hF8}};
  localparam logic [47:0] ZEROS    = {6{8'hC0}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sseg_scan_monitor_if #(.NUM_DIGITS(6)) mon_if ();

  sseg_scan_monitor #(
    .NUM_DIGITS    (6),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon_if)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fv_cnt = 0;
  int   fv_cyc = -1;
  int   dwell_cyc = 0;
  int   c0;
  logic fv_prev = 1'b0;
  logic stale_at_fv = 1'b0;
  logic stale_after_fv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame pulse monitor: pulse count, cycle of the pulse, stale around it.
  always @(negedge clk) begin
    if (fv_prev) stale_after_fv = mon_if.stale_out;
    if (mon_if.frame_valid_out === 1'b1) begin
      fv_cnt++;
      fv_cyc = cyc;
      stale_at_fv = mon_if.stale_out;
    end
    fv_prev = (mon_if.frame_valid_out === 1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [5:0] an, input logic [7:0] seg, input int n);
    dwell_cyc = cyc;
    mon_if.an_in   = an;
    mon_if.sseg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [47:0] segs, input int first, input int last, input int n);
    logic [5:0] a;
    for (int i = first; i <= last; i++) begin
      a = 6'b1 << i;
      dwell(~a, segs[8*i +: 8], n);
    end
  endtask

  task automatic frame_chk(input string tag, input logic [47:0] segs, input logic [23:0] exp_bcd,
                           input logic [5:0] exp_dp, input logic exp_err);
    int c;
    c = fv_cnt;
    scan(segs, 0, 5, 64);
    chk({tag, " pulses"}, 64'(fv_cnt - c), 64'(1));
    chk({tag, " bcd"}, 64'(mon_if.bcd_data_out), 64'(exp_bcd));
    chk({tag, " dp"}, 64'(mon_if.dp_out), 64'(exp_dp));
    chk({tag, " err"}, 64'(mon_if.glyph_err_out), 64'(exp_err));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, " bcd"}, 64'(mon_if.bcd_data_out), 64'h00FF_FFFF);
    chk({tag, " dp"}, 64'(mon_if.dp_out), 64'h0);
    chk({tag, " fv"}, 64'(mon_if.frame_valid_out), 64'h0);
    chk({tag, " err"}, 64'(mon_if.glyph_err_out), 64'h0);
    chk({tag, " stale"}, 64'(mon_if.stale_out), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    mon_if.an_in   = '1;
    mon_if.sseg_in = '1;
    repeat (3) @(posedge clk);
    #1;
    reset_chk("reset");
    rst = 1'b0;

    frame_chk("f123456", F123456, 24'h654321, 6'b000000, 1'b0);
    chk("latency", 64'(fv_cyc - dwell_cyc), 64'(SETTLE + 3));

    frame_chk("dp2", DP2, 24'h654321, 6'b000100, 1'b0);
    frame_chk("d4_all", D4_ALL, 24'h684321, 6'b010000, 1'b0);
    frame_chk("d4_blank", D4_BLANK, 24'h6F4321, 6'b000000, 1'b0);
    frame_chk("d4_bad", D4_BAD, 24'h6E4321, 6'b000000, 1'b1);
    frame_chk("clean", F123456, 24'h654321, 6'b000000, 1'b0);

    // Too-short dwells and a two-anode dwell must leave nothing behind.
    c0 = fv_cnt;
    scan(F123456, 0, 5, 10);
    dwell(6'b110011, 8'hF9, 64);
    scan(ZEROS, 0, 4, 64);
    chk("no_sample pulses", 64'(fv_cnt - c0), 64'(0));
    scan(ZEROS, 5, 5, 64);
    chk("after_short pulses", 64'(fv_cnt - c0), 64'(1));
    chk("after_short bcd", 64'(mon_if.bcd_data_out), 64'h0);

    // Stop scanning and time the stale flag from the last pulse.
    c0 = fv_cyc;
    mon_if.an_in   = '1;
    mon_if.sseg_in = '1;
    while (cyc < c0 + TOUT) @(negedge clk);
    chk("stale_before", 64'(mon_if.stale_out), 64'h0);
    @(negedge clk);
    chk("stale_rise", 64'(mon_if.stale_out), 64'h1);
    chk("stale_hold bcd", 64'(mon_if.bcd_data_out), 64'h0);
    @(posedge clk);
    #1;
    frame_chk("restart", F123456, 24'h654321, 6'b000000, 1'b0);
    chk("stale_at_fv", 64'(stale_at_fv), 64'h1);
    chk("stale_after_fv", 64'(stale_after_fv), 64'h0);

    // Reset with a partial frame of nines pending.
    scan(NINES, 0, 2, 64);
    mon_if.an_in   = '1;
    mon_if.sseg_in = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_chk("midreset");
    rst = 1'b0;
    c0 = fv_cnt;
    scan(SEVENS, 3, 5, 64);
    chk("partial pulses", 64'(fv_cnt - c0), 64'(0));
    scan(ZEROS, 0, 2, 64);
    chk("rescan pulses", 64'(fv_cnt - c0), 64'(1));
    chk("rescan bcd", 64'(mon_if.bcd_data_out), 64'h0077_7000);
    chk("rescan err", 64'(mon_if.glyph_err_out), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
